// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage; PC, ROM address, IF/ID register, redirect and HALT handling.
// Optional IF_FETCH_CNT_EN adds a saturating fetch_cnt output counting ir loads from ROM.
`default_nettype none

module if_fetch_unit #(
    parameter int            AW         = 8,
    parameter int            DW         = 16,
    parameter logic [AW-1:0] START_ADDR = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          enable,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    output logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_datain,
    output logic [DW-1:0] ir,
    output logic [AW-1:0] id_pc,
`ifdef IF_FETCH_CNT_EN
    output logic [15:0]   fetch_cnt,
`endif
    output logic          running,
    output logic          halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [4:0]    c_OP_HALT = 5'b00001;
    localparam logic [DW-1:0] c_NOP     = '0;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_ir;
    logic [AW-1:0] r_id_pc;
    logic          r_running;
    logic          r_halted;
    logic          w_is_halt;

    assign w_is_halt = (i_datain[DW-1:DW-5] == c_OP_HALT);

    assign i_addr  = r_pc;
    assign ir      = r_ir;
    assign id_pc   = r_id_pc;
    assign running = r_running;
    assign halted  = r_halted;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_pc      <= START_ADDR;
            r_ir      <= c_NOP;
            r_id_pc   <= '0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else if (enable) begin
            case (r_state)
                S_IDLE: begin
                    r_ir <= c_NOP;
                    if (start) begin
                        r_state   <= S_RUN;
                        r_pc      <= START_ADDR;
                        r_running <= 1'b1;
                        r_halted  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Redirect flushes the word fetched this cycle and beats stall/HALT.
                    if (br_taken) begin
                        r_pc    <= br_target;
                        r_ir    <= c_NOP;
                        r_id_pc <= r_pc;
                    end else if (stall) begin
                        r_pc <= r_pc;
                    end else if (w_is_halt) begin
                        r_ir      <= i_datain;
                        r_id_pc   <= r_pc;
                        r_state   <= S_HALTED;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                    end else begin
                        r_ir    <= i_datain;
                        r_id_pc <= r_pc;
                        r_pc    <= r_pc + 1'b1;
                    end
                end
                S_HALTED: begin
                    r_ir <= c_NOP;
                    if (start) begin
                        r_state   <= S_RUN;
                        r_pc      <= START_ADDR;
                        r_running <= 1'b1;
                        r_halted  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_FETCH_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic        w_load;
    logic        w_start_acc;

    assign w_load      = enable && (r_state == S_RUN) && !br_taken && !stall;
    assign w_start_acc = enable && start && (r_state != S_RUN);
    assign fetch_cnt   = r_fetch_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_cnt <= 16'h0000;
        end else if (w_start_acc) begin
            r_fetch_cnt <= 16'h0000;
        end else if (w_load && (r_fetch_cnt != 16'hFFFF)) begin
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire
